mac_accumulator: RTL and testbench



---
 rtl/mac_accumulator.sv | 172 +++++++++++++++++
 tb/tb_mac_accumulator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: multiply-accumulate stage for unsigned 8x8 operand pairs.
//   S1 registers the accepted pair, S2 registers the 16-bit product and S3 adds
//   it into an ACC_W-bit accumulator. A pair flagged last closes the block. The
//   sum, the pair count and the overflow flag are then held until the consumer
//   takes them with out_valid/out_ready.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand-pair handshake; in_ready comes from the state only
//   in_a, in_b, in_last   unsigned operands and end-of-block marker
//   out_valid/out_ready   result handshake
//   out_acc               sum of products modulo 2^ACC_W
//   out_count             number of pairs in the block, saturating at 2^CNT_W-1
//   out_ovf               set if the accumulator carried out during the block
//
// state | meaning
// ACCUM | accepting pairs, summing products as they leave S2
// DRAIN | last pair taken; waiting for it to reach the accumulator
// HOLD  | result presented on out_*, waiting for out_ready

module mac_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_e;

  state_e             state_q, state_d;
  logic               s1_valid_q, s1_valid_d;
  logic [7:0]         s1_a_q, s1_a_d;
  logic [7:0]         s1_b_q, s1_b_d;
  logic               s1_last_q, s1_last_d;
  logic               s2_valid_q, s2_valid_d;
  logic [15:0]        s2_prod_q, s2_prod_d;
  logic               s2_last_q, s2_last_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic [15:0]        mult_p;
  logic [ACC_W:0]     acc_sum;

  EightMultiplier u_mult (
    .a (s1_a_q),
    .b (s1_b_q),
    .p (mult_p)
  );

  assign in_ready  = (state_q == ACCUM);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

  // Extra top bit captures the carry out of the ACC_W-bit add.
  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(s2_prod_q);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;

    s1_valid_d = accept;
    s1_a_d     = accept ? in_a : s1_a_q;
    s1_b_d     = accept ? in_b : s1_b_q;
    s1_last_d  = accept & in_last;

    s2_valid_d = s1_valid_q;
    s2_prod_d  = s1_valid_q ? mult_p : s2_prod_q;
    s2_last_d  = s1_valid_q & s1_last_q;

    // S2 can only hold a valid entry in ACCUM or DRAIN, never in HOLD.
    if (s2_valid_q) begin
      acc_d = acc_sum[ACC_W-1:0];
      ovf_d = ovf_q | acc_sum[ACC_W];
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    case (state_q)
      ACCUM: begin
        if (accept && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (s2_valid_q && s2_last_q) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end
      end
      default: begin
        state_d     = ACCUM;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_last_q   <= s2_last_d;
    end
  end

endmodule

// EightMultiplier: combinational 8x8 unsigned array multiplier.
//   a, b  unsigned operands
//   p     16-bit product
// Each row adds the multiplicand, gated by one multiplier bit and shifted
// into place, onto the running partial sum.
module EightMultiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < 8; i++) begin
      p = p + (({8'h00, a} & {16{b[i]}}) << i);
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

  localparam int ACC_W = 24;
  localparam int CNT_W = 9;
  localparam longint ACC_MOD = longint'(1) << ACC_W;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  mac_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     q_a[$];
  int     q_b[$];
  longint exp_acc, exp_cnt, exp_ovf;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain sum of products over the block, then reduce.
  function automatic void set_expected();
    longint total = 0;
    foreach (q_a[i]) total += longint'(q_a[i]) * longint'(q_b[i]);
    exp_acc = total % ACC_MOD;
    exp_cnt = (q_a.size() > CNT_MAX) ? CNT_MAX : longint'(q_a.size());
    exp_ovf = (total >= ACC_MOD) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input int a, input int b, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_last  = last;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check_eq("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // bubble_mode: 0 none, 1 random, 2 one idle cycle before every pair but the first
  task automatic send_block(input int bubble_mode);
    set_expected();
    foreach (q_a[i]) begin
      if ((bubble_mode == 2 && i > 0) || (bubble_mode == 1 && $urandom_range(0, 1) == 1))
        tick();
      drive_pair(q_a[i], q_b[i], (i == q_a.size() - 1));
    end
  endtask

  // Called right after the last accept edge; result must appear two edges later.
  task automatic await_result(input string tag);
    int lat = 0;
    check_eq({tag, "_in_ready_low"}, longint'(in_ready), 0);
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 2);
    check_eq({tag, "_out_valid"}, longint'(out_valid), 1);
    check_eq({tag, "_out_acc"}, longint'(out_acc), exp_acc);
    check_eq({tag, "_out_count"}, longint'(out_count), exp_cnt);
    check_eq({tag, "_out_ovf"}, longint'(out_ovf), exp_ovf);
  endtask

  task automatic handshake(input string tag);
    repeat ($urandom_range(0, 2)) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_hs_out_valid"}, longint'(out_valid), 0);
    check_eq({tag, "_hs_in_ready"}, longint'(in_ready), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_in_ready"}, longint'(in_ready), 1);
    check_eq({tag, "_out_valid"}, longint'(out_valid), 0);
    check_eq({tag, "_out_acc"}, longint'(out_acc), 0);
    check_eq({tag, "_out_count"}, longint'(out_count), 0);
    check_eq({tag, "_out_ovf"}, longint'(out_ovf), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values("reset");

    // Three consecutive pairs ending with the largest product.
    q_a = '{3, 10, 255};
    q_b = '{4, 10, 255};
    send_block(0);
    await_result("basic");
    handshake("basic");

    // Single zero-product pair; in_ready must stay low until the handshake.
    q_a = '{0};
    q_b = '{200};
    send_block(0);
    await_result("single");
    tick();
    check_eq("single_hold_in_ready", longint'(in_ready), 0);
    handshake("single");

    // Enough full-scale products to carry out of the accumulator.
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < 259; i++) begin
      q_a.push_back(255);
      q_b.push_back(255);
    end
    send_block(0);
    await_result("ovf");
    handshake("ovf");

    // Consumer stalls while a new pair waits on the input.
    q_a = '{6};
    q_b = '{7};
    send_block(0);
    await_result("stall");
    in_valid = 1'b1;
    in_a     = 8'd7;
    in_b     = 8'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_out_valid", longint'(out_valid), 1);
      check_eq("stall_in_ready", longint'(in_ready), 0);
      check_eq("stall_out_acc", longint'(out_acc), exp_acc);
      check_eq("stall_out_count", longint'(out_count), exp_cnt);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("stall_release_in_ready", longint'(in_ready), 1);
    check_eq("stall_release_out_valid", longint'(out_valid), 0);
    check_eq("stall_release_out_acc", longint'(out_acc), 0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    q_a = '{7};
    q_b = '{7};
    set_expected();
    await_result("after_stall");
    handshake("after_stall");

    // Bubbles between pairs.
    q_a = '{2, 4};
    q_b = '{3, 5};
    send_block(2);
    await_result("bubble");
    handshake("bubble");

    // Reset in the middle of a block drops pairs already in the pipeline.
    drive_pair(9, 9, 1'b0);
    drive_pair(8, 8, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("midrst");
    tick();
    tick();
    check_eq("midrst_drain_count", longint'(out_count), 0);
    check_eq("midrst_drain_acc", longint'(out_acc), 0);
    q_a = '{1};
    q_b = '{1};
    send_block(0);
    await_result("post_rst");
    handshake("post_rst");

    // Random blocks with random bubbles.
    for (int blk = 0; blk < 25; blk++) begin
      int len = $urandom_range(1, 12);
      q_a.delete();
      q_b.delete();
      for (int i = 0; i < len; i++) begin
        q_a.push_back($urandom_range(0, 255));
        q_b.push_back($urandom_range(0, 255));
      end
      send_block(1);
      await_result("rand");
      handshake("rand");
    end

    // Long random block: count saturates.
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < 515; i++) begin
      q_a.push_back($urandom_range(0, 255));
      q_b.push_back($urandom_range(0, 255));
    end
    send_block(0);
    await_result("sat");
    handshake("sat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
